ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Two-requester round-robin arbiter for a single-port synchronous RAM: one write-first, one-cycle-read-latency memory instance. It lets the host-side bus (requester A, Nios data path) and the CNN accelerator datapath (requester B) share one feature/weight RAM. It issues at most one RAM access per clock, drives the RAM's write enable and output enable, and returns read data to the requester that issued the read, tagged with a one-cycle valid strobe.

## Interface

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 10, RAM address width.

Ports:
- RAM_ARB_Clk  input  1  sole clock; all state updates on rising edge.
- RAM_ARB_Reset  input  1  asynchronous, active-high reset.
- RAM_ARB_A_Req  input  1  requester A access request; held until granted.
- RAM_ARB_A_We  input  1  A access type: 1 = write, 0 = read.
- RAM_ARB_A_Address  input  ADDR_WIDTH  A address.
- RAM_ARB_A_Data_In  input  DATA_WIDTH  A write data.
- RAM_ARB_A_Gnt  output  1  A access accepted this cycle.
- RAM_ARB_A_Rvalid  output  1  A read data valid.
- RAM_ARB_A_Data_Out  output  DATA_WIDTH  A read data; 0 when A_Rvalid = 0.
- RAM_ARB_B_Req, _B_We, _B_Address, _B_Data_In, _B_Gnt, _B_Rvalid, _B_Data_Out: same as A, for requester B.
- RAM_ARB_Mem_We  output  1  to RAM write enable.
- RAM_ARB_Mem_Oe  output  1  to RAM output enable.
- RAM_ARB_Mem_Address  output  ADDR_WIDTH  to RAM address.
- RAM_ARB_Mem_Data_Out  output  DATA_WIDTH  to RAM data in.
- RAM_ARB_Mem_Data_In  input  DATA_WIDTH  from RAM data out; tri-stated by RAM when Oe = 0.

## Operation

- State:
  - `prio`: 1 bit, 0 = A favoured.
  - `rd_own`: 2-bit one-hot owner of the read in flight; 00 = none.
- Grant, combinational in the request cycle:
  - Only A requests -> A granted.
  - Only B requests -> B granted.
  - Both request -> the favoured requester is granted.
  - At most one Gnt is high per cycle.
- On a grant, the winner's address, We and data drive the Mem_* command outputs in the same cycle. The RAM samples them at the next rising edge.
- No grant: Mem_We = 0, Mem_Address = 0, Mem_Data_Out = 0.
- `prio` update at each edge with a grant: set to favour the other requester. No grant: `prio` holds.
- Granted read: `rd_own` is set to the winner at that edge. A granted write, or no grant, clears `rd_own` to 00.
- Mem_Oe = |rd_own (registered), so the RAM drives its bus only in the data cycle.
- X_Rvalid = rd_own[X]. X_Data_Out = Mem_Data_In while X_Rvalid = 1, else 0. Tri-state/X from the RAM never reaches a requester.
- Requester protocol:
  - Req, We, Address and Data_In are held stable until Gnt.
  - Req may be dropped or re-asserted with a new command in the cycle after Gnt.
  - Back-to-back accesses from one requester are allowed when uncontended: one grant per cycle.
- Memory ordering follows grant order. A read granted the cycle after a write to the same address returns the new data.

## Timing

- Reset (async, while RAM_ARB_Reset = 1): `prio` = 0, `rd_own` = 00.
  - Registered/derived outputs: Mem_Oe = 0, A_Rvalid = B_Rvalid = 0, A_Data_Out = B_Data_Out = 0.
  - Gnt and Mem_* stay combinational but are forced to 0 (no grants) while reset is high.
- Read latency: Gnt in cycle N -> Rvalid and data in cycle N+1, exactly one cycle, no backpressure.
- Write: Gnt in cycle N, RAM updated at the end of cycle N. No response strobe.
- Contention: under continuous two-sided requests, grants alternate A, B, A, B…, starting with the requester favoured at that moment. Maximum wait is 1 cycle.
- Simultaneous read data (cycle N+1) and a new grant: both proceed, giving full pipelining at one access per cycle.
- Reset asserted mid-read: the in-flight data is discarded, Rvalid drops immediately, and no response is issued after release.
- First edge after reset release: A is favoured.

## Test plan

- Reset then idle: all outputs 0, Mem_Oe = 0, no Gnt for 5 cycles.
- A writes 0x5A to address 0x010, then reads 0x010 next cycle: A_Gnt high both cycles, A_Rvalid one cycle later with A_Data_Out = 0x5A, B_Rvalid = 0.
- A and B both hold read requests (A addr 0x001, B addr 0x002, preloaded 0x11/0x22) from reset: grants A, B, A, B; Rvalid alternates A then B with data 0x11 then 0x22.
- B alone issues reads to 0x000–0x003 on 4 consecutive cycles: B_Gnt high 4 cycles, B_Rvalid high 4 cycles offset by 1, in-order data, Mem_Oe high 4 cycles.
- Contention with write/read: A writes 0x77 to 0x3FF while B reads 0x3FF in the same cycle, with A favoured: A granted first, B granted next cycle, B_Data_Out = 0x77.
- Reset asserted in the cycle after an A read grant: A_Rvalid stays 0, Mem_Oe drops immediately, and `prio` returns to favour A after release.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Requester A/B command and response signals plus the RAM-side command/data bus.
// master = arbiter side, slave = requesters and RAM.
interface ram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  RAM_ARB_A_Req;
  logic                  RAM_ARB_A_We;
  logic [ADDR_WIDTH-1:0] RAM_ARB_A_Address;
  logic [DATA_WIDTH-1:0] RAM_ARB_A_Data_In;
  logic                  RAM_ARB_A_Gnt;
  logic                  RAM_ARB_A_Rvalid;
  logic [DATA_WIDTH-1:0] RAM_ARB_A_Data_Out;

  logic                  RAM_ARB_B_Req;
  logic                  RAM_ARB_B_We;
  logic [ADDR_WIDTH-1:0] RAM_ARB_B_Address;
  logic [DATA_WIDTH-1:0] RAM_ARB_B_Data_In;
  logic                  RAM_ARB_B_Gnt;
  logic                  RAM_ARB_B_Rvalid;
  logic [DATA_WIDTH-1:0] RAM_ARB_B_Data_Out;

  logic                  RAM_ARB_Mem_We;
  logic                  RAM_ARB_Mem_Oe;
  logic [ADDR_WIDTH-1:0] RAM_ARB_Mem_Address;
  logic [DATA_WIDTH-1:0] RAM_ARB_Mem_Data_Out;
  logic [DATA_WIDTH-1:0] RAM_ARB_Mem_Data_In;

  modport master (
    input  RAM_ARB_A_Req, RAM_ARB_A_We, RAM_ARB_A_Address, RAM_ARB_A_Data_In,
    output RAM_ARB_A_Gnt, RAM_ARB_A_Rvalid, RAM_ARB_A_Data_Out,
    input  RAM_ARB_B_Req, RAM_ARB_B_We, RAM_ARB_B_Address, RAM_ARB_B_Data_In,
    output RAM_ARB_B_Gnt, RAM_ARB_B_Rvalid, RAM_ARB_B_Data_Out,
    output RAM_ARB_Mem_We, RAM_ARB_Mem_Oe, RAM_ARB_Mem_Address, RAM_ARB_Mem_Data_Out,
    input  RAM_ARB_Mem_Data_In
  );

  modport slave (
    output RAM_ARB_A_Req, RAM_ARB_A_We, RAM_ARB_A_Address, RAM_ARB_A_Data_In,
    input  RAM_ARB_A_Gnt, RAM_ARB_A_Rvalid, RAM_ARB_A_Data_Out,
    output RAM_ARB_B_Req, RAM_ARB_B_We, RAM_ARB_B_Address, RAM_ARB_B_Data_In,
    input  RAM_ARB_B_Gnt, RAM_ARB_B_Rvalid, RAM_ARB_B_Data_Out,
    input  RAM_ARB_Mem_We, RAM_ARB_Mem_Oe, RAM_ARB_Mem_Address, RAM_ARB_Mem_Data_Out,
    output RAM_ARB_Mem_Data_In
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM (1-cycle read latency)
// between two requesters; read data is routed back to the requester that issued it.
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic                RAM_ARB_Clk,
  input logic                RAM_ARB_Reset,
  ram_port_arbiter_if.master bus
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t                 prio;
  prio_t                 prio_nxt;
  logic [1:0]            rd_own;
  logic [1:0]            rd_own_nxt;
  logic                  gnt_a_c;
  logic                  gnt_b_c;
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

  // Favoured-requester state and read-owner tracking
  always_ff @(posedge RAM_ARB_Clk or posedge RAM_ARB_Reset) begin
    if (RAM_ARB_Reset) begin
      prio   <= PRIO_A;
      rd_own <= 2'b00;
    end else begin
      prio   <= prio_nxt;
      rd_own <= rd_own_nxt;
    end
  end

  // Grant selection, RAM command mux and next state; nothing is granted during reset
  always_comb begin
    gnt_a_c     = 1'b0;
    gnt_b_c     = 1'b0;
    prio_nxt    = prio;
    rd_own_nxt  = 2'b00;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    if (!RAM_ARB_Reset) begin
      if (bus.RAM_ARB_A_Req && (!bus.RAM_ARB_B_Req || prio == PRIO_A)) begin
        gnt_a_c = 1'b1;
      end else if (bus.RAM_ARB_B_Req) begin
        gnt_b_c = 1'b1;
      end
    end

    if (gnt_a_c) begin
      mem_we_c    = bus.RAM_ARB_A_We;
      mem_addr_c  = bus.RAM_ARB_A_Address;
      mem_wdata_c = bus.RAM_ARB_A_Data_In;
      prio_nxt    = PRIO_B;
      rd_own_nxt  = bus.RAM_ARB_A_We ? 2'b00 : 2'b01;
    end else if (gnt_b_c) begin
      mem_we_c    = bus.RAM_ARB_B_We;
      mem_addr_c  = bus.RAM_ARB_B_Address;
      mem_wdata_c = bus.RAM_ARB_B_Data_In;
      prio_nxt    = PRIO_A;
      rd_own_nxt  = bus.RAM_ARB_B_We ? 2'b00 : 2'b10;
    end
  end

  assign bus.RAM_ARB_A_Gnt        = gnt_a_c;
  assign bus.RAM_ARB_B_Gnt        = gnt_b_c;
  assign bus.RAM_ARB_Mem_We       = mem_we_c;
  assign bus.RAM_ARB_Mem_Address  = mem_addr_c;
  assign bus.RAM_ARB_Mem_Data_Out = mem_wdata_c;
  assign bus.RAM_ARB_Mem_Oe       = |rd_own;

  // RAM bus is only forwarded to the owning requester, so a floating bus never leaks out
  assign bus.RAM_ARB_A_Rvalid   = rd_own[0];
  assign bus.RAM_ARB_B_Rvalid   = rd_own[1];
  assign bus.RAM_ARB_A_Data_Out = rd_own[0] ? bus.RAM_ARB_Mem_Data_In : '0;
  assign bus.RAM_ARB_B_Data_Out = rd_own[1] ? bus.RAM_ARB_Mem_Data_In : '0;

endmodule
